// File: rtl/sccb_responder.sv
// SCCB/I2C target: decodes 3-phase write frames and 2-phase-write-plus-read
// frames, oversampling SIOC/SIOD on clk and pulling SIOD low only.
module sccb_responder #(
   parameter logic [7:0] DEVICE_ID = 8'h42
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sioc,
   input  logic       siod_in,
   output logic       siod_oe,
   output logic       busy,
   output logic       reg_wr,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   input  logic [7:0] reg_rdata
);

   typedef enum logic [3:0] {
      StIdle, StId, StIdAck, StReg, StRegAck, StWData, StWDataAck, StRData, StRdMack, StIgnore
   } state_t;

   logic [1:0] sioc_sync, siod_sync;
   logic       sioc_hist, siod_hist;
   logic       scl, sda, start, stop, rise, fall;

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] shift_q, shift_d, ptr_q, ptr_d, wdata_q, wdata_d;
   logic       oe_q, oe_d, busy_q, busy_d, wr_q, wr_d, rw_q, rw_d, mack_q, mack_d;
   logic [7:0] byte_in;

   // Two-flop synchronizers plus history flop; reset to idle-bus level so
   // releasing rst cannot fabricate a START.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sioc_sync <= 2'b11;
         siod_sync <= 2'b11;
         sioc_hist <= 1'b1;
         siod_hist <= 1'b1;
      end else begin
         sioc_sync <= {sioc_sync[0], sioc};
         siod_sync <= {siod_sync[0], siod_in};
         sioc_hist <= sioc_sync[1];
         siod_hist <= siod_sync[1];
      end
   end

   assign scl   = sioc_sync[1];
   assign sda   = siod_sync[1];
   assign start = scl && sioc_hist && siod_hist && !sda;
   assign stop  = scl && sioc_hist && !siod_hist && sda;
   assign rise  = scl && !sioc_hist;
   assign fall  = !scl && sioc_hist;

   assign byte_in = {shift_q[6:0], sda};

   // Frame state register; siod_oe is a flop with async clear so rst frees the bus at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 3'd0;
         shift_q <= 8'h00;
         ptr_q   <= 8'h00;
         wdata_q <= 8'h00;
         oe_q    <= 1'b0;
         busy_q  <= 1'b0;
         wr_q    <= 1'b0;
         rw_q    <= 1'b0;
         mack_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         ptr_q   <= ptr_d;
         wdata_q <= wdata_d;
         oe_q    <= oe_d;
         busy_q  <= busy_d;
         wr_q    <= wr_d;
         rw_q    <= rw_d;
         mack_q  <= mack_d;
      end
   end

   // Next-state decode; START/STOP override any bit activity in the same clk.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      ptr_d   = ptr_q;
      wdata_d = wdata_q;
      oe_d    = oe_q;
      busy_d  = busy_q;
      wr_d    = 1'b0;
      rw_d    = rw_q;
      mack_d  = mack_q;
      // Burst pointer advances the clk after the write strobe.
      if (wr_q) ptr_d = ptr_q + 8'd1;
      if (start) begin
         state_d = StId;
         cnt_d   = 3'd0;
         oe_d    = 1'b0;
         busy_d  = 1'b1;
         mack_d  = 1'b0;
      end else if (stop) begin
         state_d = StIdle;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else begin
         unique case (state_q)
            StId: if (rise) begin
               shift_d = byte_in;
               cnt_d   = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  rw_d    = sda;
                  state_d = (byte_in[7:1] == DEVICE_ID[7:1]) ? StIdAck : StIgnore;
               end
            end
            StReg: if (rise) begin
               shift_d = byte_in;
               cnt_d   = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  ptr_d   = byte_in;
                  state_d = StRegAck;
               end
            end
            StWData: if (rise) begin
               shift_d = byte_in;
               cnt_d   = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  wr_d    = 1'b1;
                  wdata_d = byte_in;
                  state_d = StWDataAck;
               end
            end
            // First fall opens the ACK slot, second fall closes it.
            StIdAck, StRegAck, StWDataAck: if (fall) begin
               if (!oe_q) begin
                  oe_d = 1'b1;
               end else begin
                  oe_d  = 1'b0;
                  cnt_d = 3'd0;
                  if (state_q == StIdAck && rw_q) begin
                     state_d = StRData;
                     shift_d = reg_rdata;
                     oe_d    = ~reg_rdata[7];
                  end else if (state_q == StIdAck) begin
                     state_d = StReg;
                  end else begin
                     state_d = StWData;
                  end
               end
            end
            // cnt wraps to 0 after the 8th rise, so a fall with cnt 0 ends the byte.
            StRData: begin
               if (rise) cnt_d = cnt_q + 3'd1;
               if (fall) begin
                  if (cnt_q == 3'd0) begin
                     oe_d    = 1'b0;
                     state_d = StRdMack;
                  end else begin
                     shift_d = {shift_q[6:0], 1'b0};
                     oe_d    = ~shift_q[6];
                  end
               end
            end
            StRdMack: begin
               if (rise) begin
                  if (!sda) begin
                     ptr_d  = ptr_q + 8'd1;
                     mack_d = 1'b1;
                  end else begin
                     state_d = StIgnore;
                  end
               end
               if (fall && mack_q) begin
                  mack_d  = 1'b0;
                  shift_d = reg_rdata;
                  oe_d    = ~reg_rdata[7];
                  state_d = StRData;
               end
            end
            default: ;
         endcase
      end
   end

   assign siod_oe   = oe_q;
   assign busy      = busy_q;
   assign reg_wr    = wr_q;
   assign reg_addr  = ptr_q;
   assign reg_wdata = wdata_q;

endmodule

// File: doc/sccb_responder.md
Name: sccb_responder

Overview:
- SCCB/I2C target (slave) that decodes the 3-phase write frames produced by the camera-configuration master, and answers 2-phase-write-plus-read frames.
- Oversamples SIOC/SIOD on the system clock and drives SIOD open-drain, low only.
- Presents decoded register accesses on a simple register-bus port.
- Used as the camera-side model in configuration testbenches, and as a configuration target for on-FPGA peripherals.

Parameters:
DEVICE_ID, 8'h42, 8-bit write address; match on bits [7:1], bit 0 of the received ID byte is R/W.

Ports:
clk  in  1  system clock; SIOC high and low phases each ≥ 8 clk
rst  in  1  asynchronous, active-high reset
sioc  in  1  SCCB clock from master
siod_in  in  1  SCCB data as seen on the pad
siod_oe  out  1  1 = pull SIOD low; 0 = release (Z)
busy  out  1  high from START detect to STOP detect
reg_wr  out  1  one-clk write strobe
reg_addr  out  8  current register pointer, driven continuously
reg_wdata  out  8  write data, valid while reg_wr=1
reg_rdata  in  8  read data for reg_addr, combinational from the user

Behaviour:
- Synchronizers: sioc and siod_in each pass through 2 flops plus 1 history flop. These reset to 1 (idle bus) so that release of rst causes no false START.
- Bus conditions, from synced values:
  - START: SDA 1→0 while SCL=1.
  - STOP: SDA 0→1 while SCL=1.
  - Sample: SCL 0→1.
  - Drive change: SCL 1→0.
- Data is MSB first. A 3-bit bit counter and an 8-bit shift register sample on SCL rising.
- States: IDLE, ID, ID_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, IGNORE.
- START from any state: go to ID, clear bit counter, siod_oe=0, busy=1. This covers repeated START.
- STOP from any state: go to IDLE, siod_oe=0, busy=0. No partial byte is written.
- ID, after 8 bits:
  - shift[7:1]==DEVICE_ID[7:1] → ID_ACK.
  - Otherwise → IGNORE. siod_oe stays 0 until the next START or STOP.
- ACK slot (ID_ACK, REG_ACK, WDATA_ACK):
  - siod_oe=1 from the SCL falling edge after the 8th bit until the next SCL falling edge, then 0.
  - Next state:
    - ID_ACK with R/W=0 → REG.
    - ID_ACK with R/W=1 → RDATA.
    - REG_ACK → WDATA.
    - WDATA_ACK → WDATA.
- REG: 8th bit loads reg_addr (pointer).
- WDATA: on the 8th-bit sample, reg_wr=1 for exactly one clk, with reg_wdata=byte and reg_addr=pointer.
  - Strobe occurs no later than 4 clk after the raw SCL rise.
  - The pointer increments (mod 256, FF→00) on the clk after the strobe, so further bytes burst-write.
- RDATA:
  - reg_rdata is captured into the shift register on the SCL falling edge that ends the preceding ACK.
  - siod_oe = ~shift[7], updated on each SCL falling edge.
  - After 8 bits, release on SCL falling → RD_MACK.
- RD_MACK: sample SDA on SCL rising.
  - 0 (ACK) → pointer+1, RDATA; the next byte is loaded on the following SCL fall.
  - 1 (NACK) → IGNORE. The bus stays released until STOP.
- A pointer loaded by a write frame persists across STOP. Reads use it. Reset clears it to 0.
- Reset values: siod_oe=0, busy=0, reg_wr=0, reg_addr=8'h00, reg_wdata=8'h00, state IDLE.
  - siod_oe is a flop output with async clear, so rst asserted mid-ACK releases the bus without waiting for clk.
  - After rst deasserts, bus activity is ignored until the next START.
- Simultaneous events: START/STOP take priority over bit sampling in the same clk.

Test Plan:
1. START, 0x42 / 0x12 / 0x80, STOP →
   - siod_oe=1 across all 3 ACK slots.
   - Single reg_wr with addr 0x12, data 0x80.
   - busy 1→0 at STOP.
2. START, 0x60 / 0x12 / 0x80, STOP → siod_oe never 1, no reg_wr, busy still toggles.
3. Write 0x42/0x0A, STOP; START 0x43 with reg_rdata=0x76 at reg_addr 0x0A; master NACK; STOP →
   - Pad shows 0x76.
   - siod_oe released in the NACK slot.
   - State returns to IDLE.
4. START 0x42 / 0xFF / 0x11 / 0x22, STOP → writes (0xFF,0x11), then (0x00,0x22), each ACKed.
5. Write frame, repeated START after 4 bits of data byte, then 0x42/0x05/0x33, STOP → only write (0x05,0x33); no write from the aborted byte.
6. Assert rst while siod_oe=1 in an ACK slot →
   - siod_oe=0 before the next clk edge; all outputs at reset values.
   - Remaining bits of the frame are ignored; no reg_wr until a new START frame.
